// File: rtl/ajuste_horario_if.sv
// Key, running-time and shadow-time signals between the time-setting controller and its neighbours.
// load is a one-cycle strobe with no back-pressure: the counters must take the shadow digits in that cycle.
interface ajuste_horario_if;
    logic       btn_mode;
    logic       btn_inc;
    logic [3:0] cur_hour_tens;
    logic [3:0] cur_hour_ones;
    logic [3:0] cur_min_tens;
    logic [3:0] cur_min_ones;
    logic [3:0] hour_tens;
    logic [3:0] hour_ones;
    logic [3:0] min_tens;
    logic [3:0] min_ones;
    logic       set_active;
    logic [1:0] field_sel;
    logic       blink;
    logic       load;

    modport master (
        output btn_mode, btn_inc,
        output cur_hour_tens, cur_hour_ones, cur_min_tens, cur_min_ones,
        input  hour_tens, hour_ones, min_tens, min_ones,
        input  set_active, field_sel, blink, load
    );

    modport slave (
        input  btn_mode, btn_inc,
        input  cur_hour_tens, cur_hour_ones, cur_min_tens, cur_min_ones,
        output hour_tens, hour_ones, min_tens, min_ones,
        output set_active, field_sel, blink, load
    );
endinterface

// File: rtl/ajuste_horario.sv
// Time-setting controller: debounced MODE/INC keys drive a RUN -> SET_HOUR -> SET_MIN editor
// over a shadow copy of the time, ending with a one-cycle load pulse to the counters.
module ajuste_horario #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_RATE     = 5000000,
    parameter int BLINK_CYCLES    = 12500000
) (
    input  logic             clk,
    input  logic             rst,
    ajuste_horario_if.slave  bus,
    output logic [1:0]       state_dbg
);
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int RW = $clog2((REPEAT_DELAY > REPEAT_RATE ? REPEAT_DELAY : REPEAT_RATE) + 1);
    localparam int BW = $clog2(BLINK_CYCLES + 1);

    typedef enum logic [1:0] {RUN = 2'd0, SET_HOUR = 2'd1, SET_MIN = 2'd2} state_t;

    // Key path, bit 0 = MODE, bit 1 = INC
    logic [1:0]    sync1, sync2, deb, deb_d, key_press;
    logic [DW-1:0] dcnt [2];

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1     <= '0;
            sync2     <= '0;
            deb       <= '0;
            deb_d     <= '0;
            key_press <= '0;
            for (int i = 0; i < 2; i++) dcnt[i] <= '0;
        end else begin
            sync1     <= {bus.btn_inc, bus.btn_mode};
            sync2     <= sync1;
            deb_d     <= deb;
            key_press <= deb & ~deb_d;
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == deb[i]) begin
                    dcnt[i] <= '0;
                end else if (dcnt[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
                    deb[i]  <= sync2[i];
                    dcnt[i] <= '0;
                end else begin
                    dcnt[i] <= dcnt[i] + 1'b1;
                end
            end
        end
    end

    function automatic logic [7:0] inc_hour(input logic [3:0] t, input logic [3:0] o);
        if (t > 4'd2 || (t == 4'd2 && o >= 4'd3)) return 8'h00;
        else if (o >= 4'd9)                      return {t + 4'd1, 4'd0};
        else                                     return {t, o + 4'd1};
    endfunction

    function automatic logic [7:0] inc_min(input logic [3:0] t, input logic [3:0] o);
        if (t > 4'd5 || (t == 4'd5 && o >= 4'd9)) return 8'h00;
        else if (o >= 4'd9)                      return {t + 4'd1, 4'd0};
        else                                     return {t, o + 4'd1};
    endfunction

    state_t        state;
    logic [3:0]    sh_ht, sh_ho, sh_mt, sh_mo;
    logic          set_active_r, blink_r, load_r;
    logic [1:0]    field_r;
    logic [BW-1:0] bcnt;
    logic [RW-1:0] rcnt;
    logic          rep_en, rep_phase, rep_p;
    logic          mode_p, inc_ev;

    assign mode_p = key_press[0];
    assign inc_ev = (key_press[1] | rep_p) & ~mode_p;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= RUN;
            {sh_ht, sh_ho, sh_mt, sh_mo} <= '0;
            set_active_r <= 1'b0;
            field_r      <= 2'b00;
            blink_r      <= 1'b0;
            load_r       <= 1'b0;
            bcnt         <= '0;
            rcnt         <= '0;
            rep_en       <= 1'b0;
            rep_phase    <= 1'b0;
            rep_p        <= 1'b0;
        end else begin
            load_r <= 1'b0;
            rep_p  <= 1'b0;
            // Repeat counts edges since the press; a new press is needed after release or any MODE press
            if (state == RUN || mode_p || !deb[1]) begin
                rep_en    <= 1'b0;
                rep_phase <= 1'b0;
                rcnt      <= '0;
            end else if (key_press[1]) begin
                rep_en    <= 1'b1;
                rep_phase <= 1'b0;
                rcnt      <= RW'(1);
            end else if (rep_en) begin
                if (rcnt == (rep_phase ? RW'(REPEAT_RATE - 1) : RW'(REPEAT_DELAY - 1))) begin
                    rep_p     <= 1'b1;
                    rep_phase <= 1'b1;
                    rcnt      <= '0;
                end else begin
                    rcnt <= rcnt + 1'b1;
                end
            end

            case (state)
                RUN: begin
                    blink_r <= 1'b0;
                    bcnt    <= '0;
                    // Hold the loaded digits one more cycle so the counters settle before tracking
                    if (!load_r) {sh_ht, sh_ho, sh_mt, sh_mo} <= {bus.cur_hour_tens, bus.cur_hour_ones,
                                                                  bus.cur_min_tens, bus.cur_min_ones};
                    if (mode_p) begin
                        state        <= SET_HOUR;
                        set_active_r <= 1'b1;
                        field_r      <= 2'b01;
                        blink_r      <= 1'b1;
                    end
                end
                SET_HOUR, SET_MIN: begin
                    if (bcnt == BW'(BLINK_CYCLES - 1)) begin
                        blink_r <= ~blink_r;
                        bcnt    <= '0;
                    end else begin
                        bcnt <= bcnt + 1'b1;
                    end
                    if (mode_p && state == SET_HOUR) begin
                        state   <= SET_MIN;
                        field_r <= 2'b10;
                    end else if (mode_p) begin
                        state        <= RUN;
                        set_active_r <= 1'b0;
                        field_r      <= 2'b00;
                        blink_r      <= 1'b0;
                        bcnt         <= '0;
                        load_r       <= 1'b1;
                    end else if (inc_ev && state == SET_HOUR) begin
                        {sh_ht, sh_ho} <= inc_hour(sh_ht, sh_ho);
                    end else if (inc_ev) begin
                        {sh_mt, sh_mo} <= inc_min(sh_mt, sh_mo);
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

    assign bus.hour_tens  = sh_ht;
    assign bus.hour_ones  = sh_ho;
    assign bus.min_tens   = sh_mt;
    assign bus.min_ones   = sh_mo;
    assign bus.set_active = set_active_r;
    assign bus.field_sel  = field_r;
    assign bus.blink      = blink_r;
    assign bus.load       = load_r;
    assign state_dbg      = state;
endmodule
